// File: rtl/posit_defines.sv
// Shared constants and bundle types for the posit<4,0> quire output stage.
// Rounding thresholds are quire magnitudes in units of 2^-4.
package posit_defines;

  localparam int QUIRE_4_0_WIDTH = 19;

  localparam logic [3:0] POSIT4_NAR    = 4'b1000;
  localparam logic [3:0] POSIT4_MAXPOS = 4'b0111;
  localparam logic [3:0] POSIT4_MINPOS = 4'b0001;
  localparam logic [3:0] POSIT4_ZERO   = 4'b0000;

  localparam logic [18:0] RND_T0 = 19'd6;
  localparam logic [18:0] RND_T1 = 19'd10;
  localparam logic [18:0] RND_T2 = 19'd14;
  localparam logic [18:0] RND_T3 = 19'd20;
  localparam logic [18:0] RND_T4 = 19'd28;
  localparam logic [18:0] RND_T5 = 19'd48;

  typedef struct packed {
    logic [QUIRE_4_0_WIDTH-1:0] data;
    logic                       zero;
    logic                       nar;
    logic                       sow;
    logic                       eow;
  } quire_item_t;

  typedef struct packed {
    logic [QUIRE_4_0_WIDTH-1:0] mag;
    logic                       neg;
    logic                       zero;
    logic                       nar;
    logic                       sow;
    logic                       eow;
  } s1_t;

endpackage

// File: rtl/posit4_round_encode.sv
// Rounds a quire magnitude to posit<4,0>, ties to the even pattern,
// saturating at maxpos and never rounding a nonzero value to zero.
module posit4_round_encode
  import posit_defines::*;
(
  input  logic [QUIRE_4_0_WIDTH-1:0] a,
  input  logic                       neg,
  input  logic                       zero,
  input  logic                       nar,
  output logic [3:0]                 posit
);

  logic [3:0] p;

  // Magnitude ladder; the >= / > choice at each step encodes the tie
  always_comb begin
    p = POSIT4_MINPOS;
    if (a > RND_T5)       p = POSIT4_MAXPOS;
    else if (a >= RND_T4) p = 4'b0110;
    else if (a > RND_T3)  p = 4'b0101;
    else if (a >= RND_T2) p = 4'b0100;
    else if (a > RND_T1)  p = 4'b0011;
    else if (a >= RND_T0) p = 4'b0010;
    else                  p = POSIT4_MINPOS;
  end

  // Special values first, then sign applied as two's complement
  always_comb begin
    posit = p;
    if (nar)
      posit = POSIT4_NAR;
    else if (zero || a == '0)
      posit = POSIT4_ZERO;
    else if (neg)
      posit = 4'(~p + 4'd1);
  end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Quire-to-posit<4,0> output stage: skid latch, abs stage, round stage.
// Optionally forwards only end-of-window results.
module quire_to_posit_4_0
  import posit_defines::*;
#(
  parameter logic ONLY_EOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rtr_o,
  input  logic        rts_i,
  input  logic        sow_i,
  input  logic        eow_i,
  input  logic [18:0] data_i,
  input  logic        sign_i,
  input  logic        zero_i,
  input  logic        NaR_i,
  input  logic        rtr_i,
  output logic        rts_o,
  output logic        sow_o,
  output logic        eow_o,
  output logic [3:0]  posit_o,
  output logic        NaR_o
);

  logic        process_en;
  logic        receive_en;
  logic        sign_unused;

  quire_item_t live;
  quire_item_t skid;
  quire_item_t pick;
  logic        skid_vld;
  logic        pick_vld;
  logic [18:0] pick_mag;

  s1_t         s1;
  logic        s1_vld;
  logic [3:0]  enc;

  assign sign_unused = sign_i;

  assign process_en = rtr_i | ~rts_o;
  assign receive_en = rts_i & rtr_o;

  assign live = '{data_i, zero_i, NaR_i, sow_i, eow_i};

  assign pick     = skid_vld ? skid : live;
  assign pick_vld = skid_vld | receive_en;
  assign pick_mag = pick.data[18] ? 19'(~pick.data + 19'd1)
                                  : pick.data;

  // Ready is registered, so one item may still land during a stall
  always_ff @(posedge clk) begin
    if (rst) rtr_o <= 1'b0;
    else     rtr_o <= process_en;
  end

  // Skid latch holds that one late item until the pipe moves again
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld <= 1'b0;
      skid     <= '0;
    end else if (process_en) begin
      skid_vld <= 1'b0;
    end else if (receive_en) begin
      skid_vld <= 1'b1;
      skid     <= live;
    end
  end

  // S1: absolute value and flags; filtered items are consumed silently
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else if (process_en) begin
      s1_vld <= pick_vld & (~ONLY_EOW | pick.eow);
      s1     <= '{pick_mag, pick.data[18], pick.zero,
                  pick.nar, pick.sow, pick.eow};
    end
  end

  posit4_round_encode u_enc (
    .a     (s1.mag),
    .neg   (s1.neg),
    .zero  (s1.zero),
    .nar   (s1.nar),
    .posit (enc)
  );

  // S2: registered result; held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      rts_o   <= 1'b0;
      posit_o <= POSIT4_ZERO;
      NaR_o   <= 1'b0;
      sow_o   <= 1'b0;
      eow_o   <= 1'b0;
    end else if (process_en) begin
      rts_o   <= s1_vld;
      posit_o <= enc;
      NaR_o   <= s1.nar;
      sow_o   <= ONLY_EOW ? s1_vld : s1.sow;
      eow_o   <= ONLY_EOW ? s1_vld : s1.eow;
    end
  end

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Bench for quire_to_posit_4_0: vector table, window filter,
// mid-flight reset and randomized back-pressure against a value model.
module tb_quire_to_posit_4_0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rts_i = 1'b0;
  logic        sow_i = 1'b0;
  logic        eow_i = 1'b0;
  logic [18:0] data_i = '0;
  logic        sign_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        nar_i = 1'b0;
  logic        rtr_i = 1'b1;
  logic        rdy1 = 1'b1;

  logic        rtr_o0, rts_o0, sow_o0, eow_o0, nar_o0;
  logic [3:0]  posit_o0;
  logic        rtr_o1, rts_o1, sow_o1, eow_o1, nar_o1;
  logic [3:0]  posit_o1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  quire_to_posit_4_0 #(.ONLY_EOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rtr_o(rtr_o0), .rts_i(rts_i),
    .sow_i(sow_i), .eow_i(eow_i), .data_i(data_i),
    .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i),
    .rtr_i(rtr_i), .rts_o(rts_o0), .sow_o(sow_o0),
    .eow_o(eow_o0), .posit_o(posit_o0), .NaR_o(nar_o0)
  );

  quire_to_posit_4_0 #(.ONLY_EOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rtr_o(rtr_o1), .rts_i(rts_i),
    .sow_i(sow_i), .eow_i(eow_i), .data_i(data_i),
    .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i),
    .rtr_i(rdy1), .rts_o(rts_o1), .sow_o(sow_o1),
    .eow_o(eow_o1), .posit_o(posit_o1), .NaR_o(nar_o1)
  );

  typedef struct packed {
    logic [18:0] d;
    logic        z;
    logic        n;
    logic [3:0]  p;
    logic        pn;
  } vec_t;

  typedef struct packed {
    logic [3:0] p;
    logic       n;
    logic       s;
    logic       e;
  } exp_t;

  vec_t vt [22];
  exp_t q [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Nearest posit value (in 1/16 units), ties to even pattern;
  // zero is never a candidate, 4.0 is the largest
  function automatic logic [3:0] ref_posit(logic [18:0] d,
                                           logic z, logic n);
    int vals [7] = '{4, 8, 12, 16, 24, 32, 64};
    int v;
    int a;
    int best;
    int bd;
    int df;
    logic [3:0] p;
    v = $signed({{13{d[18]}}, d});
    a = (v < 0) ? -v : v;
    if (n) return 4'b1000;
    if (z || a == 0) return 4'b0000;
    best = 1;
    bd = 32'h7fffffff;
    for (int k = 1; k <= 7; k++) begin
      df = a - vals[k-1];
      if (df < 0) df = -df;
      if (df < bd || (df == bd && (k % 2) == 0)) begin
        bd = df;
        best = k;
      end
    end
    p = 4'(best);
    if (v < 0) p = 4'(-best);
    return p;
  endfunction

  task automatic send(logic [18:0] d, logic z, logic n,
                      logic [3:0] ep, logic en, string nm);
    @(posedge clk); #1;
    data_i = d; sign_i = d[18]; zero_i = z; nar_i = n;
    sow_i = 1'b1; eow_i = 1'b1; rts_i = 1'b1; rtr_i = 1'b1;
    chk({nm, "_rtr"}, 32'(rtr_o0), 32'd1);
    @(posedge clk); #1;
    rts_i = 1'b0;
    chk({nm, "_lat1"}, 32'(rts_o0), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_rts"}, 32'(rts_o0), 32'd1);
    chk({nm, "_val"}, 32'({posit_o0, nar_o0, sow_o0, eow_o0}),
        32'({ep, en, 1'b1, 1'b1}));
  endtask

  initial begin
    int sent;
    int cyc;
    int cnt1;
    logic hold;
    logic never_low;
    logic seen;
    logic [7:0] saved;
    logic [3:0] last_p;
    logic last_s, last_e;
    exp_t ex;
    exp_t got;
    int r;
    int v;

    vt[0]  = '{19'd16,     1'b0, 1'b0, 4'b0100, 1'b0};
    vt[1]  = '{19'h7FFE8,  1'b0, 1'b0, 4'b1011, 1'b0};
    vt[2]  = '{19'h7FFFA,  1'b0, 1'b0, 4'b1110, 1'b0};
    vt[3]  = '{19'd48,     1'b0, 1'b0, 4'b0110, 1'b0};
    vt[4]  = '{19'd200,    1'b0, 1'b0, 4'b0111, 1'b0};
    vt[5]  = '{19'd1,      1'b0, 1'b0, 4'b0001, 1'b0};
    vt[6]  = '{19'd0,      1'b1, 1'b0, 4'b0000, 1'b0};
    vt[7]  = '{19'd5,      1'b0, 1'b1, 4'b1000, 1'b1};
    vt[8]  = '{19'd6,      1'b0, 1'b0, 4'b0010, 1'b0};
    vt[9]  = '{19'd10,     1'b0, 1'b0, 4'b0010, 1'b0};
    vt[10] = '{19'd14,     1'b0, 1'b0, 4'b0100, 1'b0};
    vt[11] = '{19'd20,     1'b0, 1'b0, 4'b0100, 1'b0};
    vt[12] = '{19'd28,     1'b0, 1'b0, 4'b0110, 1'b0};
    vt[13] = '{19'd5,      1'b0, 1'b0, 4'b0001, 1'b0};
    vt[14] = '{19'd49,     1'b0, 1'b0, 4'b0111, 1'b0};
    vt[15] = '{19'h40000,  1'b0, 1'b0, 4'b1001, 1'b0};
    vt[16] = '{19'h3FFFF,  1'b0, 1'b0, 4'b0111, 1'b0};
    vt[17] = '{19'd11,     1'b0, 1'b0, 4'b0011, 1'b0};
    vt[18] = '{19'd27,     1'b0, 1'b0, 4'b0101, 1'b0};
    vt[19] = '{19'h7FFFF,  1'b0, 1'b0, 4'b1111, 1'b0};
    vt[20] = '{19'd100,    1'b1, 1'b0, 4'b0000, 1'b0};
    vt[21] = '{19'd0,      1'b0, 1'b0, 4'b0000, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rtr", 32'(rtr_o0), 32'd0);
    chk("rst_rts", 32'(rts_o0), 32'd0);
    chk("rst_out", 32'({posit_o0, nar_o0, sow_o0, eow_o0}), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // table of single conversions
    for (int i = 0; i < 22; i++)
      send(vt[i].d, vt[i].z, vt[i].n, vt[i].p, vt[i].pn,
           $sformatf("vec%0d", i));
    repeat (3) @(posedge clk);

    // five-item window on the filtering instance
    cnt1 = 0;
    never_low = 1'b1;
    last_p = '0; last_s = 1'b0; last_e = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      rtr_i = 1'b1;
      rts_i = (c < 5);
      sow_i = (c == 0);
      eow_i = (c == 4);
      zero_i = 1'b0; nar_i = 1'b0;
      data_i = (c == 4) ? 19'd20 : 19'(8 + c);
      sign_i = 1'b0;
      @(negedge clk);
      if (!rtr_o1) never_low = 1'b0;
      if (rts_o1) begin
        cnt1++;
        last_p = posit_o1; last_s = sow_o1; last_e = eow_o1;
      end
    end
    chk("win_count", 32'(cnt1), 32'd1);
    chk("win_val", 32'({last_p, last_s, last_e}),
        32'({4'b0100, 1'b1, 1'b1}));
    chk("win_rtr", 32'(never_low), 32'd1);

    // fill skid and both stages, then reset mid-flight
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      rtr_i = 1'b0; rts_i = 1'b1;
      data_i = 19'd16; nar_i = 1'b1; sow_i = 1'b1; eow_i = 1'b1;
    end
    @(negedge clk);
    chk("fill_rts", 32'(rts_o0), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; rts_i = 1'b0;
    @(posedge clk); #1;
    chk("mrst_rts", 32'(rts_o0), 32'd0);
    chk("mrst_rtr", 32'(rtr_o0), 32'd0);
    chk("mrst_out", 32'({posit_o0, nar_o0, sow_o0, eow_o0}), 32'd0);
    rst = 1'b0; rtr_i = 1'b1; nar_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rts_o0) seen = 1'b1;
    end
    chk("mrst_flush", 32'(seen), 32'd0);
    send(19'h7FFE8, 1'b0, 1'b0, 4'b1011, 1'b0, "post_rst");
    repeat (2) @(posedge clk);

    // randomized traffic with back-pressure
    sent = 0; cyc = 0; hold = 1'b0; saved = '0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      @(posedge clk); #1;
      if (sent < 1000) begin
        rts_i = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 9);
        if (r < 6) begin
          v = int'($urandom_range(0, 140)) - 70;
          data_i = v[18:0];
        end else if (r < 8) data_i = 19'($urandom);
        else if (r == 8) data_i = 19'h40000;
        else data_i = '0;
        sign_i = data_i[18];
        zero_i = ($urandom_range(0, 15) == 0);
        nar_i = ($urandom_range(0, 19) == 0);
        sow_i = 1'($urandom);
        eow_i = 1'($urandom);
        rtr_i = ($urandom_range(0, 9) < 6);
      end else begin
        rts_i = 1'b0;
        rtr_i = 1'b1;
      end
      @(negedge clk);
      if (hold)
        chk("stall_hold",
            32'({rts_o0, posit_o0, nar_o0, sow_o0, eow_o0}),
            32'(saved));
      hold = rts_o0 & ~rtr_i;
      saved = {rts_o0, posit_o0, nar_o0, sow_o0, eow_o0};
      if (rts_o0 && rtr_i) begin
        got = '{posit_o0, nar_o0, sow_o0, eow_o0};
        if (q.size() == 0) chk("rand_extra", 32'(got), 32'hffff);
        else begin
          ex = q.pop_front();
          chk("rand_out", 32'(got), 32'(ex));
        end
      end
      if (rts_i && rtr_o0) begin
        q.push_back('{ref_posit(data_i, zero_i, nar_i), nar_i,
                      sow_i, eow_i});
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_left", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
